// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III slave-cycle controller.
//   z3_state_e   : slave-cycle FSM state encoding
//   FC_CPU_SPACE : function code for CPU space cycles, which the board never claims
//   ADDR_MATCH_W : width of the base-address compare (A[31:24])
//   addr_hit()   : board-select decode
`timescale 1ns/1ps
package z3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_IGNORE   = 3'd2,
        ST_WAIT_DS  = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_TERM     = 3'd5
    } z3_state_e;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;
    localparam int         ADDR_MATCH_W = 8;

    function automatic logic addr_hit(
        input logic                    configured,
        input logic [ADDR_MATCH_W-1:0] addr,
        input logic [ADDR_MATCH_W-1:0] base,
        input logic [2:0]              fc
    );
        return configured && (addr == base) && (fc != FC_CPU_SPACE);
    endfunction

endpackage

// File: rtl/z3_slave_cycle_if.sv
// Zorro III slave-side bus bundle between the bus/board logic and the
// slave-cycle controller.
//   FCS_n, DS_n, READ, FC, addr_hi : Zorro strobes and cycle qualifiers
//   configured, base_addr          : Autoconfig result
//   scsi_req, scsi_rd, scsi_ack    : register handshake with the SCSI block
//   SLAVE_n, DTACK_n, dtack_oe     : Zorro slave response and DTACK pad enable
//   DOE, timeout                   : data buffer enable, forced-termination pulse
// Modport slave is the controller; modport master is the driving side.
`timescale 1ns/1ps
interface z3_slave_cycle_if;
    import z3_pkg::*;

    logic                    FCS_n;
    logic [3:0]              DS_n;
    logic                    READ;
    logic [2:0]              FC;
    logic [ADDR_MATCH_W-1:0] addr_hi;
    logic                    configured;
    logic [ADDR_MATCH_W-1:0] base_addr;
    logic                    scsi_ack;

    logic                    scsi_req;
    logic                    scsi_rd;
    logic                    SLAVE_n;
    logic                    DTACK_n;
    logic                    dtack_oe;
    logic                    DOE;
    logic                    timeout;

    modport slave (
        input  FCS_n, DS_n, READ, FC, addr_hi, configured, base_addr, scsi_ack,
        output scsi_req, scsi_rd, SLAVE_n, DTACK_n, dtack_oe, DOE, timeout
    );

    modport master (
        output FCS_n, DS_n, READ, FC, addr_hi, configured, base_addr, scsi_ack,
        input  scsi_req, scsi_rd, SLAVE_n, DTACK_n, dtack_oe, DOE, timeout
    );

endinterface

// File: rtl/z3_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous active-low strobes.
//   clk   : destination clock
//   rst_n : async active-low reset; presets every stage to 1 (strobe inactive)
//   d     : asynchronous input
//   q     : synchronized output, DEPTH clocks behind d
// DEPTH must be at least 2. Bits are synchronized independently; callers
// must not rely on multi-bit coherence.
`timescale 1ns/1ps
module z3_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/z3_slave_cycle.sv
// Zorro III slave-cycle controller (A4092). Synchronizes FCS_n/DS_n, decodes
// the configured base, claims the cycle with SLAVE_n, requests a register
// access from the SCSI block and terminates with DTACK_n on ack or timeout.
//   CLK, RESET_n : board clock, async active-low reset
//   bus          : z3_slave_cycle_if.slave (strobes, decode inputs, SCSI
//                  handshake, SLAVE_n/DTACK_n/dtack_oe/DOE/timeout)
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | no cycle; releases dtack_oe left on by a previous cycle
// DECODE      | one cycle: compare address/FC/configured
// IGNORE      | not our cycle; wait for FCS_n to go away
// WAIT_DS     | board selected, waiting for any data strobe
// WAIT_ACK    | scsi_req up, waiting for scsi_ack or timeout
// TERM        | DTACK_n low until FCS_n is withdrawn
`timescale 1ns/1ps
module z3_slave_cycle
    import z3_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 63
) (
    input  logic                CLK,
    input  logic                RESET_n,
    z3_slave_cycle_if.slave     bus
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT);

    logic             fcs_s;
    logic [3:0]       ds_s;
    logic             ds_any;
    logic             hit;
    logic             abort;
    z3_state_e        state;
    logic [CNT_W-1:0] cnt;

    z3_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_fcs (
        .clk   (CLK),
        .rst_n (RESET_n),
        .d     (bus.FCS_n),
        .q     (fcs_s)
    );

    z3_sync #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync_ds (
        .clk   (CLK),
        .rst_n (RESET_n),
        .d     (bus.DS_n),
        .q     (ds_s)
    );

    assign ds_any = ~&ds_s;
    // addr_hi/FC/READ are held stable by board logic for the whole cycle,
    // so they are used directly without synchronization.
    assign hit    = addr_hit(bus.configured, bus.addr_hi, bus.base_addr, bus.FC);
    // Master gave up before termination: drop everything, no timeout pulse.
    assign abort  = fcs_s && (state inside {ST_DECODE, ST_WAIT_DS, ST_WAIT_ACK});

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus.SLAVE_n  <= 1'b1;
            bus.DTACK_n  <= 1'b1;
            bus.dtack_oe <= 1'b0;
            bus.DOE      <= 1'b0;
            bus.scsi_req <= 1'b0;
            bus.scsi_rd  <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            if (abort) begin
                // dtack_oe stays up here and is cleared by IDLE one cycle later.
                state        <= ST_IDLE;
                bus.SLAVE_n  <= 1'b1;
                bus.DTACK_n  <= 1'b1;
                bus.DOE      <= 1'b0;
                bus.scsi_req <= 1'b0;
                bus.scsi_rd  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // DTACK_n was driven high for one cycle before release.
                        bus.dtack_oe <= 1'b0;
                        if (!fcs_s) begin
                            state <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        if (hit) begin
                            state        <= ST_WAIT_DS;
                            bus.SLAVE_n  <= 1'b0;
                            bus.dtack_oe <= 1'b1;
                            bus.scsi_rd  <= bus.READ;
                        end else begin
                            state        <= ST_IGNORE;
                            bus.scsi_rd  <= 1'b0;
                        end
                    end
                    ST_IGNORE: begin
                        if (fcs_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_WAIT_DS: begin
                        if (ds_any) begin
                            state        <= ST_WAIT_ACK;
                            bus.scsi_req <= 1'b1;
                            bus.DOE      <= bus.scsi_rd;
                            cnt          <= '0;
                        end
                    end
                    ST_WAIT_ACK: begin
                        // Ack has priority over a timeout expiring in the same cycle.
                        if (bus.scsi_ack) begin
                            state        <= ST_TERM;
                            bus.DTACK_n  <= 1'b0;
                            bus.scsi_req <= 1'b0;
                        end else if (cnt == CNT_TC) begin
                            state        <= ST_TERM;
                            bus.DTACK_n  <= 1'b0;
                            bus.scsi_req <= 1'b0;
                            bus.timeout  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TERM: begin
                        if (fcs_s) begin
                            state       <= ST_IDLE;
                            bus.SLAVE_n <= 1'b1;
                            bus.DTACK_n <= 1'b1;
                            bus.DOE     <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
